// File: rtl/tt_project_select.sv
// Project selector: pad pins step an address, one-hot enable plus input routing to the addressed wrapper, outputs muxed back to pads.
// Latency: pad select pins 3 clk edges to effect, ow_proj->ow_pad 1 cycle, iw_pad->proj_iw combinational; no backpressure.
module tt_project_select #(
    parameter int N_PROJ  = 16,
    parameter int ADDR_W  = 4,
    parameter int IW_W    = 18,
    parameter int OW_W    = 24,
    parameter int GAP_CYC = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sel_rst_n,
    input  logic                     sel_inc,
    input  logic                     sel_ena,
    input  logic [IW_W-1:0]          iw_pad,
    output logic [OW_W-1:0]          ow_pad,
    output logic [N_PROJ-1:0]        proj_ena,
    output logic [N_PROJ*IW_W-1:0]   proj_iw,
    input  logic [N_PROJ*OW_W-1:0]   ow_proj,
    output logic [ADDR_W-1:0]        cur_addr
);

    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0]  GAP_LOAD  = GAP_W'(GAP_CYC - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PROJ - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACTIVE = 2'd1;
    localparam logic [1:0] GAP    = 2'd2;

    // Synchronizer chains; the inc chain carries one extra stage for edge detection.
    logic [1:0] rst_n_sync_q, rst_n_sync_d;
    logic [1:0] ena_sync_q,   ena_sync_d;
    logic [2:0] inc_sync_q,   inc_sync_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        state_q, state_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic [N_PROJ-1:0] proj_ena_q, proj_ena_d;
    logic [OW_W-1:0]   ow_pad_q, ow_pad_d;

    logic sel_rst_n_s;
    logic sel_ena_s;
    logic inc_edge;
    logic addr_chg;
    logic [OW_W-1:0] ow_sel;

    always_comb begin
        rst_n_sync_d = {rst_n_sync_q[0], sel_rst_n};
        ena_sync_d   = {ena_sync_q[0], sel_ena};
        inc_sync_d   = {inc_sync_q[1:0], sel_inc};
        sel_rst_n_s  = rst_n_sync_q[1];
        sel_ena_s    = ena_sync_q[1];
        inc_edge     = inc_sync_q[1] & ~inc_sync_q[2];
    end

    always_comb begin
        addr_d = addr_q;
        if (!sel_rst_n_s) begin
            addr_d = '0;
        end else if (inc_edge) begin
            addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + ADDR_W'(1);
        end
        addr_chg = (addr_d != addr_q);

        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (sel_ena_s) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (addr_chg) begin
                    state_d   = GAP;
                    gap_cnt_d = GAP_LOAD;
                end else if (!sel_ena_s) begin
                    state_d = IDLE;
                end
            end
            GAP: begin
                // A further address change keeps every slot dark for a full gap again.
                if (addr_chg) begin
                    gap_cnt_d = GAP_LOAD;
                end else if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end else begin
                    state_d = sel_ena_s ? ACTIVE : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        proj_ena_d = '0;
        ow_sel     = '0;
        for (int k = 0; k < N_PROJ; k++) begin
            if (state_d == ACTIVE && addr_d == ADDR_W'(k)) proj_ena_d[k] = 1'b1;
            if (addr_q == ADDR_W'(k)) ow_sel = ow_proj[k*OW_W +: OW_W];
        end
        ow_pad_d = (state_q == ACTIVE) ? ow_sel : '0;
    end

    // The project clock rides on iw_pad[0], so routing stays combinational.
    always_comb begin
        proj_iw = '0;
        for (int k = 0; k < N_PROJ; k++) begin
            proj_iw[k*IW_W +: IW_W] = proj_ena_q[k] ? iw_pad : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rst_n_sync_q <= 2'b11;
            ena_sync_q   <= 2'b00;
            inc_sync_q   <= 3'b000;
            addr_q       <= '0;
            state_q      <= IDLE;
            gap_cnt_q    <= '0;
            proj_ena_q   <= '0;
            ow_pad_q     <= '0;
        end else begin
            rst_n_sync_q <= rst_n_sync_d;
            ena_sync_q   <= ena_sync_d;
            inc_sync_q   <= inc_sync_d;
            addr_q       <= addr_d;
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            proj_ena_q   <= proj_ena_d;
            ow_pad_q     <= ow_pad_d;
        end
    end

    assign proj_ena = proj_ena_q;
    assign ow_pad   = ow_pad_q;
    assign cur_addr = addr_q;

endmodule

// File: tb/tb_tt_project_select.sv
// Bench for tt_project_select: vector table, directed corner sequences, random run against a cycle model.
module tb_tt_project_select;

    localparam int N    = 16;
    localparam int IW   = 18;
    localparam int OW   = 24;
    localparam int GAPC = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            sel_rst_n;
    logic            sel_inc;
    logic            sel_ena;
    logic [IW-1:0]   iw_pad;
    logic [OW-1:0]   ow_pad;
    logic [N-1:0]    proj_ena;
    logic [N*IW-1:0] proj_iw;
    logic [N*OW-1:0] ow_proj;
    logic [3:0]      cur_addr;

    int n_chk = 0;
    int n_err = 0;

    // Model: address as an integer, an enabled flag and the number of dark cycles still owed.
    int            m_addr;
    int            m_gap;
    bit            m_act;
    logic [OW-1:0] m_ow;
    bit [1:0]      h_ena;
    bit [1:0]      h_rst;
    bit [2:0]      h_inc;

    tt_project_select #(.N_PROJ(N), .ADDR_W(4), .IW_W(IW), .OW_W(OW), .GAP_CYC(GAPC)) dut (
        .clk(clk), .rst(rst), .sel_rst_n(sel_rst_n), .sel_inc(sel_inc), .sel_ena(sel_ena),
        .iw_pad(iw_pad), .ow_pad(ow_pad), .proj_ena(proj_ena), .proj_iw(proj_iw),
        .ow_proj(ow_proj), .cur_addr(cur_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            n_inc;
        logic [IW-1:0] iw;
        logic [OW-1:0] ow;
        logic [N-1:0]  exp_ena;
        logic [3:0]    exp_addr;
    } vec_t;

    vec_t vt[5];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [OW-1:0] slot_val(input int k);
        return OW'(24'h5A0001 + k * 24'h000101);
    endfunction

    task automatic fill_slots();
        for (int k = 0; k < N; k++) ow_proj[k*OW +: OW] = slot_val(k);
    endtask

    task automatic model_reset();
        m_addr = 0;
        m_gap  = 0;
        m_act  = 1'b0;
        m_ow   = '0;
        h_ena  = 2'b00;
        h_rst  = 2'b11;
        h_inc  = 3'b000;
    endtask

    task automatic model_edge();
        int na;
        bit chg;
        bit ena_s;
        bit rise;
        ena_s = h_ena[1];
        rise  = h_inc[1] && !h_inc[2];
        m_ow  = (m_gap == 0 && m_act) ? ow_proj[m_addr*OW +: OW] : '0;
        if (!h_rst[1]) na = 0;
        else if (rise) na = (m_addr + 1) % N;
        else na = m_addr;
        chg = (na != m_addr);
        if (m_gap > 0) begin
            if (chg) m_gap = GAPC;
            else if (m_gap > 1) m_gap--;
            else begin
                m_gap = 0;
                m_act = ena_s;
            end
        end else if (m_act && chg) begin
            m_gap = GAPC;
        end else begin
            m_act = ena_s;
        end
        m_addr = na;
        h_ena  = {h_ena[0], sel_ena};
        h_rst  = {h_rst[0], sel_rst_n};
        h_inc  = {h_inc[1:0], sel_inc};
    endtask

    task automatic check_model();
        logic [N-1:0]    e;
        logic [N*IW-1:0] iwx;
        e   = '0;
        iwx = '0;
        if (m_gap == 0 && m_act) begin
            e[m_addr] = 1'b1;
            iwx[m_addr*IW +: IW] = iw_pad;
        end
        chk("model_ena", 512'(proj_ena), 512'(e));
        chk("model_ow", 512'(ow_pad), 512'(m_ow));
        chk("model_addr", 512'(cur_addr), 512'(m_addr));
        chk("model_iw", 512'(proj_iw), 512'(iwx));
        chk("onehot", 512'($countones(proj_ena) <= 1), 512'(1));
    endtask

    task automatic tick();
        if (rst) model_reset();
        else model_edge();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic wait_n(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_inc(input int n);
        repeat (n) begin
            sel_inc = 1'b1;
            wait_n(2);
            sel_inc = 1'b0;
            wait_n(2);
        end
    endtask

    initial begin
        logic [N*IW-1:0] exp_iw;
        rst = 1'b1; sel_rst_n = 1'b1; sel_inc = 1'b0; sel_ena = 1'b0;
        iw_pad = 18'h12345;
        fill_slots();
        model_reset();
        #2;
        wait_n(2);
        chk("rst_ena", 512'(proj_ena), 512'(0));
        chk("rst_ow", 512'(ow_pad), 512'(0));
        chk("rst_addr", 512'(cur_addr), 512'(0));
        chk("rst_iw", 512'(proj_iw), 512'(0));

        vt[0] = '{0,  18'h3FFFF, 24'hFFFFFF, 16'h0001, 4'd0};
        vt[1] = '{3,  18'h2A5A5, 24'hC0FFEE, 16'h0008, 4'd3};
        vt[2] = '{9,  18'h00001, 24'h000001, 16'h0200, 4'd9};
        vt[3] = '{15, 18'h1B3C7, 24'h123456, 16'h8000, 4'd15};
        vt[4] = '{17, 18'h15555, 24'hAAAAAA, 16'h0002, 4'd1};
        for (int i = 0; i < 5; i++) begin
            rst = 1'b1; sel_ena = 1'b0; sel_inc = 1'b0; sel_rst_n = 1'b1;
            tick();
            rst = 1'b0;
            pulse_inc(vt[i].n_inc);
            fill_slots();
            ow_proj[(vt[i].n_inc % N)*OW +: OW] = vt[i].ow;
            iw_pad  = vt[i].iw;
            sel_ena = 1'b1;
            wait_n(3);
            exp_iw = '0;
            exp_iw[vt[i].exp_addr*IW +: IW] = vt[i].iw;
            chk("vec_ena", 512'(proj_ena), 512'(vt[i].exp_ena));
            chk("vec_addr", 512'(cur_addr), 512'(vt[i].exp_addr));
            chk("vec_iw", 512'(proj_iw), 512'(exp_iw));
            tick();
            chk("vec_ow", 512'(ow_pad), 512'(vt[i].ow));
        end

        // Reset release with sel_ena held: slot 0 lights on the third edge.
        fill_slots();
        rst = 1'b1; sel_ena = 1'b1;
        tick();
        rst = 1'b0;
        wait_n(2);
        chk("t1_ena_early", 512'(proj_ena), 512'(0));
        tick();
        chk("t1_ena", 512'(proj_ena), 512'(16'h0001));
        tick();
        chk("t1_ow", 512'(ow_pad), 512'(slot_val(0)));

        // Active switch 3 -> 4: two dark cycles, output bus dark one cycle later.
        pulse_inc(3);
        wait_n(3);
        chk("t2_ena3", 512'(proj_ena), 512'(16'h0008));
        sel_inc = 1'b1;
        wait_n(2);
        chk("t2_hold", 512'(proj_ena), 512'(16'h0008));
        tick();
        sel_inc = 1'b0;
        chk("t2_gap0", 512'(proj_ena), 512'(0));
        chk("t2_ow_last", 512'(ow_pad), 512'(slot_val(3)));
        tick();
        chk("t2_gap1", 512'(proj_ena), 512'(0));
        chk("t2_ow_gap0", 512'(ow_pad), 512'(0));
        tick();
        chk("t2_ena4", 512'(proj_ena), 512'(16'h0010));
        chk("t2_ow_gap1", 512'(ow_pad), 512'(0));
        tick();
        chk("t2_ow4", 512'(ow_pad), 512'(slot_val(4)));

        // Idle wrap through all sixteen addresses.
        sel_ena = 1'b0;
        wait_n(4);
        pulse_inc(11);
        chk("t3_addr15", 512'(cur_addr), 512'(15));
        for (int i = 0; i < 16; i++) begin
            pulse_inc(1);
            chk("t3_addr", 512'(cur_addr), 512'(i));
            chk("t3_ena", 512'(proj_ena), 512'(0));
            chk("t3_ow", 512'(ow_pad), 512'(0));
        end

        // Address clear overrides increments, then a second step restarts the gap.
        pulse_inc(8);
        sel_ena = 1'b1;
        wait_n(4);
        chk("t4_ena7", 512'(proj_ena), 512'(16'h0080));
        sel_rst_n = 1'b0; sel_inc = 1'b1;
        wait_n(3);
        chk("t4_clr_addr", 512'(cur_addr), 512'(0));
        chk("t4_clr_ena", 512'(proj_ena), 512'(0));
        sel_inc = 1'b0;
        tick();
        chk("t4_gap", 512'(proj_ena), 512'(0));
        pulse_inc(2);
        chk("t4_held_addr", 512'(cur_addr), 512'(0));
        chk("t4_ena0", 512'(proj_ena), 512'(16'h0001));
        sel_rst_n = 1'b1;
        wait_n(3);
        sel_inc = 1'b1; tick();
        sel_inc = 1'b0; tick();
        sel_inc = 1'b1; tick();
        chk("t4_step1", 512'(cur_addr), 512'(1));
        chk("t4_dark1", 512'(proj_ena), 512'(0));
        sel_inc = 1'b0; tick();
        chk("t4_dark2", 512'(proj_ena), 512'(0));
        tick();
        chk("t4_step2", 512'(cur_addr), 512'(2));
        chk("t4_dark3", 512'(proj_ena), 512'(0));
        tick();
        chk("t4_dark4", 512'(proj_ena), 512'(0));
        tick();
        chk("t4_ena2", 512'(proj_ena), 512'(16'h0004));

        // Enable drop and a runt enable pulse that never spans an edge.
        sel_ena = 1'b0;
        wait_n(2);
        chk("t5_still", 512'(proj_ena), 512'(16'h0004));
        tick();
        chk("t5_off", 512'(proj_ena), 512'(0));
        chk("t5_ow_last", 512'(ow_pad), 512'(slot_val(2)));
        tick();
        chk("t5_ow_off", 512'(ow_pad), 512'(0));
        sel_ena = 1'b1;
        #2;
        sel_ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_runt", 512'(proj_ena), 512'(0));
        end

        // Asynchronous reset between clock edges.
        sel_ena = 1'b1;
        wait_n(4);
        chk("t6_pre_ow", 512'(ow_pad), 512'(slot_val(2)));
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_ena", 512'(proj_ena), 512'(0));
        chk("t6_async_ow", 512'(ow_pad), 512'(0));
        chk("t6_async_addr", 512'(cur_addr), 512'(0));
        model_reset();
        tick();
        rst = 1'b0;
        wait_n(2);
        chk("t6_wait", 512'(proj_ena), 512'(0));
        tick();
        chk("t6_resume", 512'(proj_ena), 512'(16'h0001));

        // Random pads and wrapper outputs against the model.
        repeat (1500) begin
            rst       = ($urandom_range(0, 299) == 0);
            sel_rst_n = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 2) == 0) sel_inc = ~sel_inc;
            if ($urandom_range(0, 11) == 0) sel_ena = ~sel_ena;
            iw_pad = IW'($urandom);
            for (int k = 0; k < N; k++) ow_proj[k*OW +: OW] = OW'($urandom);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
